// File: rtl/sdp_fifo_ctrl.sv
// FIFO controller for a simple-dual-port RAM with a registered read port.
// A 2-entry output queue hides the read latency, so the FIFO can move one word per cycle.
module sdp_fifo_ctrl #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic [AWIDTH+1:0] count,
    output logic              mem_wce,
    output logic [AWIDTH-1:0] mem_wa,
    output logic [DWIDTH-1:0] mem_wd,
    output logic              mem_rce,
    output logic [AWIDTH-1:0] mem_ra,
    input  logic [DWIDTH-1:0] mem_rq
);

    localparam logic [AWIDTH:0]   DEPTH_C   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   CNT_ONE_C = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] PTR_ONE_C = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] wptr_r;
    logic [AWIDTH-1:0] rptr_r;
    logic [AWIDTH:0]   mem_cnt_r;
    logic [1:0]        q_cnt_r;
    logic              inflight_r;
    logic [DWIDTH-1:0] head_r;
    logic [DWIDTH-1:0] tail_r;
    logic              m_valid_r;
    logic              s_ready_r;
    logic [AWIDTH+1:0] count_r;

    logic              push_s;
    logic              pop_s;
    logic              issue_s;
    logic [2:0]        occ_s;
    logic [AWIDTH:0]   mem_cnt_next_s;
    logic [1:0]        q_cnt_next_s;
    logic [DWIDTH-1:0] head_next_s;
    logic [DWIDTH-1:0] tail_next_s;
    logic [AWIDTH+1:0] count_next_s;

    // Handshakes and read issue; reads stop once the queue plus in-flight word would exceed 2
    always_comb begin
        push_s  = rst_n & s_valid & s_ready_r;
        pop_s   = m_valid_r & m_ready;
        occ_s   = {1'b0, q_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s = rst_n & (mem_cnt_r != {(AWIDTH+1){1'b0}}) & (occ_s < 3'd2);
    end

    // RAM occupancy: words written but not yet read-issued
    always_comb begin
        mem_cnt_next_s = mem_cnt_r;
        case ({push_s, issue_s})
            2'b10:   mem_cnt_next_s = mem_cnt_r + CNT_ONE_C;
            2'b01:   mem_cnt_next_s = mem_cnt_r - CNT_ONE_C;
            default: mem_cnt_next_s = mem_cnt_r;
        endcase
    end

    // Output queue: the returning read word lands in the head if the head is free after a pop
    always_comb begin
        q_cnt_next_s = q_cnt_r;
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        case ({inflight_r, pop_s})
            2'b10: begin
                if (q_cnt_r == 2'd0) begin
                    head_next_s  = mem_rq;
                    q_cnt_next_s = 2'd1;
                end else begin
                    tail_next_s  = mem_rq;
                    q_cnt_next_s = 2'd2;
                end
            end
            2'b11: begin
                if (q_cnt_r == 2'd1) begin
                    head_next_s = mem_rq;
                end else begin
                    head_next_s = tail_r;
                    tail_next_s = mem_rq;
                end
            end
            2'b01: begin
                if (q_cnt_r == 2'd2) begin
                    head_next_s  = tail_r;
                    q_cnt_next_s = 2'd1;
                end else begin
                    q_cnt_next_s = 2'd0;
                end
            end
            default: begin
                q_cnt_next_s = q_cnt_r;
            end
        endcase
    end

    // Total occupancy seen by the next cycle
    always_comb begin
        count_next_s = {1'b0, mem_cnt_next_s}
                     + {{AWIDTH{1'b0}}, q_cnt_next_s}
                     + {{(AWIDTH+1){1'b0}}, issue_s};
    end

    // State registers; a read in flight at reset is dropped by clearing inflight_r
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r     <= {AWIDTH{1'b0}};
            rptr_r     <= {AWIDTH{1'b0}};
            mem_cnt_r  <= {(AWIDTH+1){1'b0}};
            q_cnt_r    <= 2'd0;
            inflight_r <= 1'b0;
            head_r     <= {DWIDTH{1'b0}};
            tail_r     <= {DWIDTH{1'b0}};
            m_valid_r  <= 1'b0;
            s_ready_r  <= 1'b0;
            count_r    <= {(AWIDTH+2){1'b0}};
        end else begin
            wptr_r     <= push_s  ? wptr_r + PTR_ONE_C : wptr_r;
            rptr_r     <= issue_s ? rptr_r + PTR_ONE_C : rptr_r;
            mem_cnt_r  <= mem_cnt_next_s;
            q_cnt_r    <= q_cnt_next_s;
            inflight_r <= issue_s;
            head_r     <= head_next_s;
            tail_r     <= tail_next_s;
            m_valid_r  <= (q_cnt_next_s != 2'd0);
            s_ready_r  <= (mem_cnt_next_s < DEPTH_C);
            count_r    <= count_next_s;
        end
    end

    assign s_ready = s_ready_r;
    assign m_valid = m_valid_r;
    assign m_data  = head_r;
    assign count   = count_r;
    assign mem_wce = push_s;
    assign mem_wa  = wptr_r;
    assign mem_wd  = s_data;
    assign mem_rce = issue_s;
    assign mem_ra  = rptr_r;

endmodule

// File: doc/sdp_fifo_ctrl.md
# sdp_fifo_ctrl

Synchronous FIFO controller that drives a simple-dual-port block RAM: one write port (`wce`/`wa`/`wd`) and one registered read port (`rce`/`ra`/`rq`, 1-cycle latency, `rq` holds when `rce`=0).
- Upstream sees a valid/ready push interface; downstream sees a first-word-fall-through valid/ready pop interface.
- The controller hides the RAM read latency with a 2-entry output queue and sustains one word per cycle in both directions.
- The RAM macro is instantiated by the parent; this block only generates its control.

## Interface
- AWIDTH, 9, RAM address width; RAM depth DEPTH = 2^AWIDTH
- DWIDTH, 32, data width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- s_valid  in  1  push request
- s_ready  out  1  push accept (registered)
- s_data  in  DWIDTH  push data
- m_valid  out  1  pop data available (registered)
- m_ready  in  1  pop accept
- m_data  out  DWIDTH  head-of-FIFO data (registered)
- count  out  AWIDTH+2  total occupancy, RAM entries plus output-queue entries plus in-flight read
- mem_wce  out  1  RAM write enable = s_valid & s_ready
- mem_wa  out  AWIDTH  RAM write address = wptr
- mem_wd  out  DWIDTH  RAM write data = s_data
- mem_rce  out  1  RAM read enable = issue
- mem_ra  out  AWIDTH  RAM read address = rptr
- mem_rq  in  DWIDTH  RAM read data, valid the cycle after mem_rce

## Operation
- Push: on s_valid & s_ready, write s_data at wptr; wptr += 1 mod DEPTH; mem_cnt += 1.
- mem_cnt (0..DEPTH) counts words written to RAM but not yet read-issued.
- Output queue: 2 entries (q_cnt 0..2), head drives m_data.
- Pop: on m_valid & m_ready, drop the head; q_cnt -= 1.
- Issue rule, combinational: issue = rst_n & (mem_cnt != 0) & (q_cnt + inflight - pop < 2).
- A word written in cycle N contributes to mem_cnt from N+1, so it is never read in its write cycle. RAM read-during-write behaviour is therefore irrelevant.
- On issue: rptr += 1 mod DEPTH; mem_cnt -= 1; inflight <= 1 (else 0).
- Cycle after issue (inflight = 1): capture mem_rq into the queue tail. If q_cnt = 0 or the head is popped with q_cnt = 1, the captured word becomes head.
- mem_rq is ignored whenever inflight = 0.
- Simultaneous push and issue in one cycle: mem_cnt unchanged. Wrap-around of wptr and rptr is natural modulo 2^AWIDTH.
- s_ready next = (mem_cnt_next < DEPTH). Full: s_ready = 0 while mem_cnt = DEPTH; a push attempted then is neither written nor counted.
- Empty: m_valid = 0 and m_data holds its last value. Popping with m_valid = 0 has no effect.
- count = mem_cnt + q_cnt + inflight; maximum value DEPTH + 2.

## Timing
- Reset (rst_n = 0 at a clock edge):
  - wptr, rptr, mem_cnt, q_cnt, inflight, count = 0
  - m_valid = 0, s_ready = 0, m_data = 0
  - mem_rce and mem_wce are 0 throughout reset.
- s_ready rises 1 cycle after rst_n releases.
- Reset mid-operation: all stored words are discarded, and a read in flight at reset is dropped (its mem_rq is not captured).
- Push-to-pop latency, empty FIFO:
  - push accepted in cycle 0
  - mem_rce in cycle 1
  - mem_rq valid in cycle 2
  - m_valid = 1 with the word in cycle 3
- Throughput: with s_valid and m_ready held high, after the 3-cycle fill one word is popped every cycle with no bubbles.
- Downstream stall: with m_ready = 0, the queue fills to 2 and issue stops. When m_ready returns, pops continue back-to-back.
- m_valid, m_data, s_ready and count are registered. mem_wce, mem_wa, mem_wd, mem_rce and mem_ra are combinational.

## Test plan
- Reset/idle:
  - hold rst_n = 0 for 3 cycles, then release
  - required: all outputs 0 during reset; s_ready = 1 one cycle after release; m_valid stays 0; mem_rce never asserted.
- Single word:
  - push 0xDEADBEEF in cycle 0 with m_ready = 1
  - required: mem_wce = 1 with mem_wa = 0 in cycle 0; mem_rce = 1 with mem_ra = 0 in cycle 1; m_valid = 1 with m_data = 0xDEADBEEF in cycle 3; m_valid = 0 in cycle 4; count goes 0,1,1,1,0.
- Streaming:
  - push words 0..1023 back-to-back with m_ready = 1 (AWIDTH = 9)
  - required: pops come out in order, one per cycle from cycle 3; pointers wrap 511 to 0 without loss; count never exceeds 3.
- Full:
  - m_ready = 0, push continuously
  - required: exactly DEPTH + 2 = 514 words accepted; s_ready = 0 from then on; count = 514.
  - then pulse m_ready for 1 cycle: s_ready = 1 again within 2 cycles, and the next pushed word appears last in pop order.
- Random stall:
  - random s_valid and m_ready at 50% each for 10k cycles
  - required: output sequence matches the scoreboard; count equals the model; no push is accepted when full; m_valid is never 1 when empty.
- Reset mid-operation:
  - assert rst_n = 0 for 1 cycle, in the cycle right after a mem_rce, with count = 5
  - required: next cycle count = 0 and m_valid = 0; the stale mem_rq is not output; pushes after release start at wptr = 0.
